line_arbiter_n: RTL and testbench
=================================

LINE_ARBITER_N -- requirements
Module: line_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of line-level requesters (L1 caches / L2 miss ports), legal 2..8.
REQ-002 SHALL have parameter LINE_WIDTH, default 256: cacheline width in bits.
REQ-003 SHALL have parameter RR_MODE, default 1: 1 = round-robin priority, 0 = fixed priority (port 0 highest).
REQ-004 One clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_address  input  NUM_PORTS*32  per-port line address, port p at bits [32p+31:32p].
REQ-008 req_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, same packing.
REQ-009 req_read  input  NUM_PORTS  per-port read request, level, held until that port's req_resp.
REQ-010 req_write  input  NUM_PORTS  per-port write request, level, held until that port's req_resp.
REQ-011 req_rdata  output  LINE_WIDTH  read line broadcast to all ports, valid only with req_resp.
REQ-012 req_resp  output  NUM_PORTS  one-hot completion pulse.
REQ-013 mem_address  output  32  downstream line address (to cacheline adaptor).
REQ-014 mem_wdata  output  LINE_WIDTH  downstream write line.
REQ-015 mem_read / mem_write  output  1 each  downstream request, level.
REQ-016 mem_rdata  input  LINE_WIDTH  downstream read line.
REQ-017 mem_resp  input  1  downstream completion, one-cycle pulse.
REQ-018 grant_id  output  $clog2(NUM_PORTS)  index of the port owning the downstream; busy  output  1  high in BUSY or DONE.

Function
REQ-019 FSM SHALL have states IDLE, BUSY and DONE.
REQ-020 IDLE: a port is pending when req_read|req_write is set; if any port is pending, the winner SHALL be chosen combinationally, and its address, wdata, op and index SHALL be registered, moving to BUSY next edge.
REQ-021 Winner selection, RR_MODE=1: first pending port scanning from rr_ptr upward, modulo NUM_PORTS; on grant, rr_ptr <= winner+1, wrapping NUM_PORTS-1 -> 0.
REQ-022 Winner selection, RR_MODE=0: lowest-index pending port; rr_ptr unused, held 0.
REQ-023 If a port asserts both read and write, the write SHALL be issued; read is ignored for that transaction.
REQ-024 BUSY: mem_read/mem_write SHALL be driven from registered op, mem_address/mem_wdata from registers; all stable for the whole transaction regardless of requester inputs.
REQ-025 BUSY with mem_resp=1: req_resp[grant_id]=1 and req_rdata=mem_rdata in the same cycle (combinational pass-through); next state DONE.
REQ-026 DONE: one guard cycle, mem_read=mem_write=0, req_resp=0 (lets the requester drop a stale request); next state IDLE unconditionally.
REQ-027 Latency: request visible at edge N in IDLE -> mem_read/mem_write high from cycle N+1; minimum spacing between downstream requests is 2 idle cycles (DONE, IDLE).
REQ-028 req_resp SHALL never be asserted outside BUSY; mem_resp in IDLE/DONE SHALL be ignored.
REQ-029 req_rdata SHALL be 0 when req_resp is all-zero.
REQ-030 Requests arriving on other ports during BUSY/DONE SHALL wait; no request is dropped; in RR_MODE=1 every continuously pending port is granted within NUM_PORTS transactions.
REQ-031 grant_id SHALL hold the registered winner in BUSY/DONE and be 0 in IDLE.

Reset
REQ-032 On rst: state IDLE, rr_ptr 0, grant_id 0, busy 0, mem_read 0, mem_write 0, mem_address 0, mem_wdata 0, req_resp 0, req_rdata 0, all effective the cycle after the rst edge.
REQ-033 rst mid-BUSY SHALL abandon the transaction without req_resp; a mem_resp arriving afterwards SHALL be ignored.

Verification
REQ-034 Single read: port 1 read addr 0x0000_1040, mem_resp after 5 cycles with rdata 0xA5..A5 -> mem_read high from cycle 1, req_resp=2'b10 with matching rdata, DONE then IDLE.
REQ-035 Simultaneous: NUM_PORTS=2, RR_MODE=1, both ports read from reset -> port 0 granted first, then port 1, then port 0 again if both still pending.
REQ-036 Fixed priority: RR_MODE=0, port 0 re-requests immediately after each resp while port 1 pending -> port 0 granted every time.
REQ-037 Write precedence: port 0 read=1 write=1 addr 0x200, wdata 0x1234.. -> mem_write=1, mem_read=0, mem_wdata=0x1234...
REQ-038 Wrap: NUM_PORTS=4, RR, all 4 pending -> grant order 0,1,2,3,0; rr_ptr wraps 3->0.
REQ-039 Reset mid-op: rst during BUSY, then mem_resp -> no req_resp pulse, mem_read low, state IDLE.

Source files
------------

// File: rtl/line_arbiter_n.sv
// Line-level arbiter: NUM_PORTS cacheline requesters share one downstream port,
// one transaction at a time, round-robin or fixed priority, with a DONE guard cycle.

module line_arbiter_n_port #(
  parameter int IDW = 1,
  parameter int IDX = 0
) (
  input  logic           rd,
  input  logic           wr,
  input  logic           resp_en,
  input  logic [IDW-1:0] gnt,
  output logic           pend,
  output logic           wr_op,
  output logic           resp
);
  assign pend  = rd | wr;
  // a port raising both read and write gets a write
  assign wr_op = wr;
  assign resp  = resp_en && (gnt == IDW'(IDX));
endmodule

module line_arbiter_n #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*32-1:0]         req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  output logic [LINE_WIDTH-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [31:0]                     mem_address,
  output logic [LINE_WIDTH-1:0]           mem_wdata,
  output logic                            mem_read,
  output logic                            mem_write,
  input  logic [LINE_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_resp,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);
  localparam int IDW = $clog2(NUM_PORTS);
  localparam int CW  = IDW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_PORTS-1:0][31:0]           addr_v;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] wdata_v;
  logic [NUM_PORTS-1:0]                 pend;
  logic [NUM_PORTS-1:0]                 wr_op;
  logic [IDW-1:0]                       rr_ptr;
  logic [IDW-1:0]                       gnt_q;
  logic [IDW-1:0]                       win_idx;
  logic [IDW-1:0]                       ptr_nxt;
  logic [CW-1:0]                        cand;
  logic                                 win_vld;
  logic                                 op_wr_q;
  logic                                 resp_en;
  logic [31:0]                          addr_q;
  logic [LINE_WIDTH-1:0]                wdata_q;

  assign addr_v  = req_address;
  assign wdata_v = req_wdata;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    line_arbiter_n_port #(.IDW(IDW), .IDX(g)) u_port (
      .rd      (req_read[g]),
      .wr      (req_write[g]),
      .resp_en (resp_en),
      .gnt     (gnt_q),
      .pend    (pend[g]),
      .wr_op   (wr_op[g]),
      .resp    (req_resp[g])
    );
  end

  // scan starts at rr_ptr (or 0 in fixed mode); one wrap subtraction suffices
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (RR_MODE != 0) ? CW'(rr_ptr) + CW'(i) : CW'(i);
      if (cand >= CW'(NUM_PORTS)) cand = cand - CW'(NUM_PORTS);
      if (!win_vld && pend[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  assign ptr_nxt = (win_idx == IDW'(NUM_PORTS - 1)) ? '0 : win_idx + IDW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_vld) begin
        gnt_q   <= win_idx;
        op_wr_q <= wr_op[win_idx];
        addr_q  <= addr_v[win_idx];
        wdata_q <= wdata_v[win_idx];
        if (RR_MODE != 0) rr_ptr <= ptr_nxt;
      end
    end
  end

  // downstream is driven only from the captured copy, never from live requester inputs
  assign resp_en     = (state_q == BUSY) && mem_resp;
  assign mem_read    = (state_q == BUSY) && !op_wr_q;
  assign mem_write   = (state_q == BUSY) && op_wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign req_rdata   = resp_en ? mem_rdata : '0;
  assign busy        = (state_q != IDLE);
  assign grant_id    = (state_q == IDLE) ? '0 : gnt_q;

endmodule

// File: tb/tb_line_arbiter_n.sv
// Bench for line_arbiter_n: a round-robin and a fixed-priority instance share stimulus;
// each scenario checks one of them against a small arbitration model.

module tb_line_arbiter_n;
  localparam int NP = 4;
  localparam int LW = 64;

  typedef struct {
    logic          bsy;
    logic [1:0]    gid;
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [LW-1:0] wd;
    logic          stable;
    logic [NP-1:0] resp;
    logic [LW-1:0] rdata;
    logic          done_ok;
    logic          idle_ok;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0][31:0]   req_address;
  logic [NP-1:0][LW-1:0] req_wdata;
  logic [NP-1:0]         req_read;
  logic [NP-1:0]         req_write;
  logic [LW-1:0]         mem_rdata;
  logic                  mem_resp;

  logic [LW-1:0] o_rdata [2];
  logic [NP-1:0] o_resp  [2];
  logic [31:0]   o_addr  [2];
  logic [LW-1:0] o_wd    [2];
  logic          o_rd    [2];
  logic          o_wr    [2];
  logic          o_busy  [2];
  logic [1:0]    o_gid   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line_arbiter_n #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_address(req_address), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write), .req_rdata(o_rdata[0]), .req_resp(o_resp[0]),
    .mem_address(o_addr[0]), .mem_wdata(o_wd[0]), .mem_read(o_rd[0]), .mem_write(o_wr[0]),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .grant_id(o_gid[0]), .busy(o_busy[0])
  );

  line_arbiter_n #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .req_address(req_address), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write), .req_rdata(o_rdata[1]), .req_resp(o_resp[1]),
    .mem_address(o_addr[1]), .mem_wdata(o_wd[1]), .mem_read(o_rd[1]), .mem_write(o_wr[1]),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .grant_id(o_gid[1]), .busy(o_busy[1])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference arbitration: first pending port from ptr (round-robin) or from 0 (fixed).
  function automatic int pick(input logic [NP-1:0] pend, input int ptr, input bit rr);
    int p;
    for (int i = 0; i < NP; i++) begin
      p = rr ? (ptr + i) % NP : i;
      if (pend[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [43:0] ctl(input obs_t o);
    return {o.bsy, o.gid, o.rd, o.wr, o.addr, o.resp, o.stable, o.done_ok, o.idle_ok};
  endfunction

  function automatic logic [43:0] exp_ctl(input int p, input logic wr, input logic [31:0] addr);
    return {1'b1, 2'(p), ~wr, wr, addr, 4'(1 << p), 3'b111};
  endfunction

  task automatic apply_reset;
    req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Runs one downstream transaction with the requests already set up; returns what was seen.
  task automatic do_txn(input int d, input int lat, input logic [LW-1:0] rdat,
                        input bit again, input logic [31:0] again_addr, output obs_t o);
    @(negedge clk);
    o.bsy = o_busy[d]; o.gid = o_gid[d]; o.rd = o_rd[d]; o.wr = o_wr[d];
    o.addr = o_addr[d]; o.wd = o_wd[d]; o.stable = 1'b1;
    for (int c = 1; c < lat; c++) begin
      mem_rdata = {$urandom, $urandom};
      for (int i = 0; i < NP; i++)
        if (!(req_read[i] | req_write[i])) begin
          req_address[i] = $urandom;
          req_wdata[i]   = {$urandom, $urandom};
        end
      #1;
      if (o_resp[d] !== '0 || o_rdata[d] !== '0) o.stable = 1'b0;
      @(negedge clk);
      if ({o_busy[d], o_gid[d], o_rd[d], o_wr[d], o_addr[d], o_wd[d]} !==
          {o.bsy, o.gid, o.rd, o.wr, o.addr, o.wd}) o.stable = 1'b0;
    end
    mem_resp = 1'b1; mem_rdata = rdat;
    #1;
    o.resp = o_resp[d]; o.rdata = o_rdata[d];
    @(negedge clk);
    mem_rdata = {$urandom, $urandom};
    #1;
    o.done_ok = (o_busy[d] === 1'b1) && (o_rd[d] === 1'b0) && (o_wr[d] === 1'b0) &&
                (o_resp[d] === '0) && (o_rdata[d] === '0);
    req_read[o.gid] = 1'b0; req_write[o.gid] = 1'b0;
    if (again) begin
      req_read[o.gid]    = 1'b1;
      req_address[o.gid] = again_addr;
    end
    @(negedge clk);
    #1;
    o.idle_ok = (o_busy[d] === 1'b0) && (o_gid[d] === 2'd0) && (o_rd[d] === 1'b0) &&
                (o_wr[d] === 1'b0) && (o_resp[d] === '0) && (o_rdata[d] === '0);
    mem_resp = 1'b0;
  endtask

  task automatic test_reset;
    req_address = '1; req_wdata = '1; req_read = 4'b0001; req_write = 4'b0010;
    mem_resp = 1'b1; mem_rdata = '1;
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_busy[d], o_gid[d], o_rd[d], o_wr[d], o_addr[d], o_resp[d], o_wd[d], o_rdata[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got busy=%b gid=%0d rd=%b wr=%b addr=%h resp=%b wd=%h rdata=%h, want all zero",
                 d, o_busy[d], o_gid[d], o_rd[d], o_wr[d], o_addr[d], o_resp[d], o_wd[d], o_rdata[d]);
      end
    end
    req_read = '0; req_write = '0; mem_resp = 1'b0; rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_busy[d], o_rd[d], o_wr[d], o_resp[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: got busy=%b rd=%b wr=%b resp=%b, want idle",
                 d, o_busy[d], o_rd[d], o_wr[d], o_resp[d]);
      end
    end
  endtask

  task automatic test_single_read;
    obs_t o;
    logic [LW-1:0] ew;
    logic [LW-1:0] rdat;
    apply_reset;
    rdat = {8{8'hA5}};
    req_address[1] = 32'h0000_1040; req_read[1] = 1'b1;
    ew = req_wdata[1];
    do_txn(0, 5, rdat, 1'b0, 32'h0, o);
    n_chk++;
    if (ctl(o) !== exp_ctl(1, 1'b0, 32'h0000_1040)) begin
      n_fail++; $display("FAIL single_read ctl: got %h want %h", ctl(o), exp_ctl(1, 1'b0, 32'h0000_1040));
    end
    n_chk++;
    if ({o.wd, o.rdata} !== {ew, rdat}) begin
      n_fail++; $display("FAIL single_read data: got %h want %h", {o.wd, o.rdata}, {ew, rdat});
    end
  endtask

  task automatic test_simultaneous;
    obs_t o;
    int ord [3] = '{0, 1, 0};
    logic [31:0] ea;
    logic [LW-1:0] ew;
    logic [LW-1:0] rdat;
    apply_reset;
    req_address[0] = 32'h0000_A000; req_address[1] = 32'h0000_B000;
    req_wdata[0] = 64'h11; req_wdata[1] = 64'h22;
    req_read = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      ea = req_address[ord[k]]; ew = req_wdata[ord[k]]; rdat = {$urandom, $urandom};
      do_txn(0, k + 1, rdat, 1'b1, 32'h0000_4000 + 32'(k * 64), o);
      n_chk++;
      if (ctl(o) !== exp_ctl(ord[k], 1'b0, ea) || {o.wd, o.rdata} !== {ew, rdat}) begin
        n_fail++; $display("FAIL simultaneous txn%0d: got gid=%0d ctl=%h want port %0d ctl=%h",
                           k, o.gid, ctl(o), ord[k], exp_ctl(ord[k], 1'b0, ea));
      end
    end
  endtask

  task automatic test_fixed_priority;
    obs_t o;
    int ord [5]   = '{0, 0, 0, 0, 1};
    bit again [5] = '{1, 1, 1, 0, 0};
    logic [31:0] ea;
    logic [LW-1:0] rdat;
    apply_reset;
    req_address[0] = 32'h0000_A000; req_address[1] = 32'h0000_B000;
    req_read = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      ea = req_address[ord[k]]; rdat = {$urandom, $urandom};
      do_txn(1, 2, rdat, again[k], 32'h0000_A040 + 32'(k * 64), o);
      n_chk++;
      if (ctl(o) !== exp_ctl(ord[k], 1'b0, ea) || o.rdata !== rdat) begin
        n_fail++; $display("FAIL fixed_priority txn%0d: got gid=%0d ctl=%h want port %0d ctl=%h",
                           k, o.gid, ctl(o), ord[k], exp_ctl(ord[k], 1'b0, ea));
      end
    end
  endtask

  task automatic test_write_precedence;
    obs_t o;
    logic [LW-1:0] rdat;
    apply_reset;
    rdat = {$urandom, $urandom};
    req_address[0] = 32'h0000_0200; req_wdata[0] = 64'h1234_5678_9ABC_DEF0;
    req_read[0] = 1'b1; req_write[0] = 1'b1;
    do_txn(0, 3, rdat, 1'b0, 32'h0, o);
    n_chk++;
    if (ctl(o) !== exp_ctl(0, 1'b1, 32'h0000_0200)) begin
      n_fail++; $display("FAIL write_precedence ctl: got %h want %h", ctl(o), exp_ctl(0, 1'b1, 32'h0000_0200));
    end
    n_chk++;
    if (o.wd !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++; $display("FAIL write_precedence wdata: got %h want %h", o.wd, 64'h1234_5678_9ABC_DEF0);
    end
  endtask

  task automatic test_wrap;
    obs_t o;
    int ord [5] = '{0, 1, 2, 3, 0};
    logic [31:0] ea;
    logic [LW-1:0] ew;
    apply_reset;
    for (int i = 0; i < NP; i++) begin
      req_address[i] = 32'h0001_0000 * 32'(i + 1); req_wdata[i] = {$urandom, $urandom};
    end
    req_read = '1;
    for (int k = 0; k < 5; k++) begin
      ea = req_address[ord[k]]; ew = req_wdata[ord[k]];
      do_txn(0, 1, '0, 1'b1, 32'h0008_0000 + 32'(k * 64), o);
      n_chk++;
      if (ctl(o) !== exp_ctl(ord[k], 1'b0, ea) || o.wd !== ew) begin
        n_fail++; $display("FAIL wrap txn%0d: got gid=%0d ctl=%h want port %0d ctl=%h",
                           k, o.gid, ctl(o), ord[k], exp_ctl(ord[k], 1'b0, ea));
      end
    end
  endtask

  task automatic test_reset_mid_op;
    apply_reset;
    req_address[2] = 32'h0000_3000; req_read[2] = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_busy[0], o_rd[0], o_gid[0]} !== {1'b1, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL midop_busy: got busy=%b rd=%b gid=%0d want 1 1 2", o_busy[0], o_rd[0], o_gid[0]);
    end
    @(negedge clk);
    rst = 1'b1; req_read[2] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_busy[d], o_rd[d], o_wr[d], o_gid[d]} !== '0) begin
        n_fail++; $display("FAIL midop_abort dut%0d: got busy=%b rd=%b wr=%b gid=%0d want 0",
                           d, o_busy[d], o_rd[d], o_wr[d], o_gid[d]);
      end
    end
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({o_resp[d], o_rdata[d]} !== '0) begin
        n_fail++; $display("FAIL midop_late_resp dut%0d: got resp=%b rdata=%h want 0", d, o_resp[d], o_rdata[d]);
      end
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({o_busy[0], o_resp[0], o_rd[0]} !== '0) begin
      n_fail++; $display("FAIL midop_idle: got busy=%b resp=%b rd=%b want 0", o_busy[0], o_resp[0], o_rd[0]);
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_random(input int d);
    obs_t o;
    int ptr, p, kind, maxw;
    int wait_cnt [NP];
    logic [NP-1:0] pend;
    logic [31:0] ea;
    logic [LW-1:0] ew;
    logic [LW-1:0] rdat;
    logic ewr;
    apply_reset;
    ptr = 0;
    wait_cnt = '{default: 0};
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NP; i++)
        if (!(req_read[i] | req_write[i]) && $urandom_range(0, 1) == 1) begin
          kind = $urandom_range(0, 2);
          req_read[i]    = (kind != 1);
          req_write[i]   = (kind != 0);
          req_address[i] = $urandom & 32'hFFFF_FFC0;
          req_wdata[i]   = {$urandom, $urandom};
        end
      if ((req_read | req_write) == '0) req_write[$urandom_range(0, NP - 1)] = 1'b1;
      pend = req_read | req_write;
      p    = pick(pend, ptr, d == 0);
      ea   = req_address[p]; ew = req_wdata[p]; ewr = req_write[p];
      rdat = {$urandom, $urandom};
      do_txn(d, $urandom_range(1, 4), rdat, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFC0, o);
      n_chk++;
      if (ctl(o) !== exp_ctl(p, ewr, ea) || {o.wd, o.rdata} !== {ew, rdat}) begin
        n_fail++; $display("FAIL random dut%0d txn%0d: got gid=%0d ctl=%h want port %0d ctl=%h",
                           d, t, o.gid, ctl(o), p, exp_ctl(p, ewr, ea));
      end
      if (d == 0) begin
        ptr  = (p + 1) % NP;
        maxw = 0;
        for (int i = 0; i < NP; i++) begin
          wait_cnt[i] = (pend[i] && i != p) ? wait_cnt[i] + 1 : 0;
          if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
        end
        n_chk++;
        if (maxw > NP - 1) begin
          n_fail++; $display("FAIL random_fairness txn%0d: a port waited %0d grants, limit %0d", t, maxw, NP - 1);
        end
      end
    end
  endtask

  initial begin
    req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    test_reset;
    test_single_read;
    test_simultaneous;
    test_fixed_priority;
    test_write_precedence;
    test_wrap;
    test_reset_mid_op;
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
